sram_wbuf_ctrl: RTL and testbench
=================================

# sram_wbuf_ctrl

Port controller in front of the 32x256 single-port masked data array: accepts read/write requests on one valid/ready channel, parks writes in a 2-entry coalescing write buffer, issues reads with priority, and returns read data through a held response register. Buffered-write bytes are forwarded into read responses so read-after-write is correct. Sits directly upstream of the array macro and drives its RW0 port.

## Interface
- ADDR_W, 5, array address width (32 rows)
- DATA_W, 256, row width
- MASK_W, 8, write-mask lanes (32 bits per lane)
- WBUF_DEPTH, 2, write-buffer entries
- clock  in  1  sole clock
- reset_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when high with req_valid
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  row address
- req_wmask  in  MASK_W  write lane mask (ignored for reads)
- req_wdata  in  DATA_W  write data
- resp_valid  out  1  read data valid, held until resp_ready
- resp_ready  in  1  consumer accepts response
- resp_data  out  DATA_W  read data
- arr_en, arr_wmode  out  1 each  array enable / write mode
- arr_addr  out  ADDR_W;  arr_wmask  out  MASK_W;  arr_wdata  out  DATA_W  array command
- arr_rdata  in  DATA_W  array data, valid the cycle after a read issue

## Operation
- Reset: buffer empty, rd_inflight=0, resp_valid=0, resp_data=0, arr_en=0, arr_wmode=0.
- Write accept: req_ready=1 if buffer not full, or youngest valid entry has same address and is not draining this cycle (coalesce), or buffer full and draining this cycle. Coalesce: per lane, new lane data overwrites; entry mask |= req_wmask.
- Read accept: req_ready=1 iff !rd_inflight && (!resp_valid || resp_ready) && buffer not full. At most one read in flight or held; peak 1 read per 2 cycles.
- Array arbitration per cycle: rd_issue = accepted read; else drain = buffer non-empty. Read wins unless buffer full (then reads stall, drain forced). Drain issues oldest entry: arr_en=1, arr_wmode=1, entry addr/mask/data; entry popped same cycle.
- arr_* outputs combinational from current request and state; arr_en=0 when idle, other arr_* don't-care (drive 0).
- Forwarding: at rd_issue, per lane, select data from youngest valid entry with matching address and lane mask bit set; register fwd_mask[MASK_W], fwd_data[DATA_W]. Writes accepted after the read are never forwarded into it.
- Capture: cycle after rd_issue, resp_data = per lane fwd_mask ? fwd_data : arr_rdata; resp_valid=1; rd_inflight cleared.
- Response fire (resp_valid && resp_ready) clears resp_valid; resp_data holds stable while resp_valid && !resp_ready.
- reset_n low mid-operation: buffered writes discarded, in-flight read dropped, all outputs to reset values immediately.

## Timing
- Read: accept at T -> arr_en at T -> resp_valid at T+1 (registered).
- Write: accept at T -> earliest array write T+1 (entry visible to drain next cycle; no same-cycle pass-through).
- Buffer full + write + drain same cycle: pop head, push new; count unchanged.
- Coalesce and drain of the same entry same cycle forbidden (not ready unless another free slot).
- req_ready may depend on req_write/req_addr; never on resp_* except resp_ready in read term.

## Structure
- Package sram_wbuf_pkg: ADDR_W, DATA_W, MASK_W, LANE_W=DATA_W/MASK_W constants; wbuf_entry_t {valid, addr, mask, data}.
- Sub-module sram_wbuf_fifo: entry storage, head/tail pointers, push/pop/coalesce, combinational forward lookup (addr in -> fwd_mask, fwd_data). Top holds arbitration, read pipe and response register.

## Test plan
- Reset, then write addr 3 mask 0xFF data A; read addr 3 -> resp_data=A, array written before or forwarded, exactly one arr write.
- Write addr 5 mask 0x01 data X; immediate read addr 5 -> lane0 = X[31:0], lanes 1-7 from array old contents.
- Two writes addr 7 masks 0x0F then 0xF0 back-to-back -> coalesced: single array write, mask 0xFF.
- Fill buffer (addr 1, 2), third write addr 4 -> accepted same cycle as drain of addr 1; read held low-ready until not full.
- Read with resp_ready=0 for 5 cycles -> resp_data stable, next read req_ready=0 until fire.
- Assert reset_n low with one buffered write and read in flight -> resp_valid=0, arr_en=0, buffer empty; post-reset read returns old array data.

Source files
------------

// File: rtl/sram_wbuf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_wbuf_pkg
// Purpose  : Shared constants, write-buffer entry type and a lane-merge helper
//            for the SRAM write-buffer port controller.
// Contents : ADDR_W, DATA_W, MASK_W, LANE_W, WBUF_DEPTH, wbuf_entry_t,
//            lane_merge()
// Revision : 1.0 - initial release
// ============================================================================
package sram_wbuf_pkg;

    localparam int ADDR_W     = 5;
    localparam int DATA_W     = 256;
    localparam int MASK_W     = 8;
    localparam int LANE_W     = DATA_W / MASK_W;
    localparam int WBUF_DEPTH = 2;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [MASK_W-1:0] mask;
        logic [DATA_W-1:0] data;
    } wbuf_entry_t;

    // Per lane: take lane from a where sel is set, otherwise from b.
    function automatic logic [DATA_W-1:0] lane_merge(
        input logic [MASK_W-1:0] sel,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [DATA_W-1:0] r;
        r = b;
        for (int l = 0; l < MASK_W; l++) begin
            if (sel[l]) begin
                r[l*LANE_W +: LANE_W] = a[l*LANE_W +: LANE_W];
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_wbuf_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_wbuf_ctrl_if
// Purpose  : Request / response channel between a client and the SRAM port
//            controller.
// Ports    : req_valid/req_ready/req_write/req_addr/req_wmask/req_wdata
//            resp_valid/resp_ready/resp_data
//            master = client side, slave = controller side
// Revision : 1.0 - initial release
// ============================================================================
interface sram_wbuf_ctrl_if;
    import sram_wbuf_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [MASK_W-1:0] req_wmask;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;

    modport master (
        output req_valid, req_write, req_addr, req_wmask, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wmask, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_data
    );

endinterface
`default_nettype wire

// File: rtl/sram_wbuf_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sram_wbuf_fifo
// Purpose  : Two-entry coalescing write buffer with combinational read
//            forwarding lookup.
// Ports    : clk, rst_n            clock, async active-low reset
//            push_i/coalesce_i/pop_i  buffer operations (mutually consistent,
//                                  decided by the controller)
//            wr_addr_i/wr_mask_i/wr_data_i  incoming write
//            lk_addr_i             forwarding lookup address
//            full_o, one_o         occupancy flags
//            young_match_o         youngest valid entry matches wr_addr_i
//            head_o                oldest entry (next to drain)
//            fwd_mask_o/fwd_data_o lanes forwarded for lk_addr_i
// Revision : 1.0 - initial release
// ============================================================================
module sram_wbuf_fifo
    import sram_wbuf_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic              coalesce_i,
    input  logic              pop_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [MASK_W-1:0] wr_mask_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] lk_addr_i,
    output logic              full_o,
    output logic              one_o,
    output logic              young_match_o,
    output wbuf_entry_t       head_o,
    output logic [MASK_W-1:0] fwd_mask_o,
    output logic [DATA_W-1:0] fwd_data_o
);

    wbuf_entry_t ent_q [WBUF_DEPTH];
    wbuf_entry_t ent_d [WBUF_DEPTH];
    logic        head_q, head_d;
    logic [1:0]  count_q, count_d;
    logic        w_tail;
    logic        w_young;

    // Depth is two, so pointers are single bits: tail = head + count and
    // youngest = head + count - 1, both modulo 2.
    assign w_tail  = head_q ^ count_q[0];
    assign w_young = head_q ^ ~count_q[0];

    assign full_o        = (count_q == 2'd2);
    assign one_o         = (count_q == 2'd1);
    assign head_o        = ent_q[head_q];
    assign young_match_o = ent_q[w_young].valid && (ent_q[w_young].addr == wr_addr_i);

    always_comb begin
        ent_d   = ent_q;
        head_d  = head_q;
        if (pop_i) begin
            ent_d[head_q].valid = 1'b0;
            head_d              = ~head_q;
        end
        // When full, the tail slot equals the head slot being popped.
        if (push_i) begin
            ent_d[w_tail] = '{valid: 1'b1, addr: wr_addr_i, mask: wr_mask_i, data: wr_data_i};
        end
        if (coalesce_i) begin
            ent_d[w_young].mask = ent_q[w_young].mask | wr_mask_i;
            ent_d[w_young].data = lane_merge(wr_mask_i, wr_data_i, ent_q[w_young].data);
        end
        count_d = count_q + 2'(push_i) - 2'(pop_i);
    end

    // Walk oldest to youngest so the youngest matching entry wins per lane.
    always_comb begin
        fwd_mask_o = '0;
        fwd_data_o = '0;
        for (int i = 0; i < WBUF_DEPTH; i++) begin
            if (ent_q[head_q ^ 1'(i)].valid && (ent_q[head_q ^ 1'(i)].addr == lk_addr_i)) begin
                for (int l = 0; l < MASK_W; l++) begin
                    if (ent_q[head_q ^ 1'(i)].mask[l]) begin
                        fwd_mask_o[l]                     = 1'b1;
                        fwd_data_o[l*LANE_W +: LANE_W]    = ent_q[head_q ^ 1'(i)].data[l*LANE_W +: LANE_W];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= 1'b0;
            count_q <= '0;
            for (int i = 0; i < WBUF_DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            count_q <= count_d;
            ent_q   <= ent_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_wbuf_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_wbuf_ctrl
// Purpose  : Port controller for a 32x256 single-port masked SRAM. Parks
//            writes in a coalescing buffer, issues reads with priority,
//            forwards buffered bytes into read data, holds the response.
// Ports    : clk, rst_n      clock, async active-low reset
//            host            request/response channel (slave modport)
//            arr_en_o, arr_wmode_o, arr_addr_o, arr_wmask_o, arr_wdata_o
//                            array RW0 command (combinational)
//            arr_rdata_i     array read data, valid the cycle after a read
// Revision : 1.0 - initial release
// ============================================================================
module sram_wbuf_ctrl
    import sram_wbuf_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    sram_wbuf_ctrl_if.slave   host,
    output logic              arr_en_o,
    output logic              arr_wmode_o,
    output logic [ADDR_W-1:0] arr_addr_o,
    output logic [MASK_W-1:0] arr_wmask_o,
    output logic [DATA_W-1:0] arr_wdata_o,
    input  logic [DATA_W-1:0] arr_rdata_i
);

    logic              w_full, w_one, w_young_match;
    wbuf_entry_t       w_head;
    logic [MASK_W-1:0] w_fwd_mask;
    logic [DATA_W-1:0] w_fwd_data;
    logic              w_is_wr, w_rd_ready, w_rd_issue, w_drain;
    logic              w_young_draining, w_wr_ready, w_wr_acc, w_coalesce, w_push;

    logic              rd_inflight_q, rd_inflight_d;
    logic [MASK_W-1:0] fwd_mask_q, fwd_mask_d;
    logic [DATA_W-1:0] fwd_data_q, fwd_data_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;

    // Reset gates the combinational outputs so they go idle immediately.
    assign w_is_wr    = host.req_valid && host.req_write;
    assign w_rd_ready = rst_n && !rd_inflight_q && (!resp_valid_q || host.resp_ready) && !w_full;
    assign w_rd_issue = host.req_valid && !host.req_write && w_rd_ready;

    // Drains use array cycles not taken by a read; they are deferred while
    // writes stream in (so back-to-back writes can coalesce) unless the
    // buffer is full, in which case the head is forced out.
    assign w_drain = rst_n && w_head.valid && !w_rd_issue && (w_full || !w_is_wr);

    // With one entry the youngest is also the head, so it cannot coalesce
    // while draining.
    assign w_young_draining = w_drain && w_one;
    assign w_wr_ready = rst_n && (!w_full || (w_young_match && !w_young_draining) || w_drain);
    assign w_wr_acc   = w_is_wr && w_wr_ready;
    assign w_coalesce = w_wr_acc && w_young_match && !w_young_draining;
    assign w_push     = w_wr_acc && !w_coalesce;

    assign host.req_ready  = host.req_write ? w_wr_ready : w_rd_ready;
    assign host.resp_valid = resp_valid_q;
    assign host.resp_data  = resp_data_q;

    sram_wbuf_fifo u_fifo (
        .clk           (clk),
        .rst_n         (rst_n),
        .push_i        (w_push),
        .coalesce_i    (w_coalesce),
        .pop_i         (w_drain),
        .wr_addr_i     (host.req_addr),
        .wr_mask_i     (host.req_wmask),
        .wr_data_i     (host.req_wdata),
        .lk_addr_i     (host.req_addr),
        .full_o        (w_full),
        .one_o         (w_one),
        .young_match_o (w_young_match),
        .head_o        (w_head),
        .fwd_mask_o    (w_fwd_mask),
        .fwd_data_o    (w_fwd_data)
    );

    always_comb begin
        arr_en_o    = 1'b0;
        arr_wmode_o = 1'b0;
        arr_addr_o  = '0;
        arr_wmask_o = '0;
        arr_wdata_o = '0;
        if (w_rd_issue) begin
            arr_en_o   = 1'b1;
            arr_addr_o = host.req_addr;
        end else if (w_drain) begin
            arr_en_o    = 1'b1;
            arr_wmode_o = 1'b1;
            arr_addr_o  = w_head.addr;
            arr_wmask_o = w_head.mask;
            arr_wdata_o = w_head.data;
        end
    end

    always_comb begin
        rd_inflight_d = w_rd_issue;
        fwd_mask_d    = fwd_mask_q;
        fwd_data_d    = fwd_data_q;
        resp_valid_d  = resp_valid_q;
        resp_data_d   = resp_data_q;
        // Forwarding snapshot is taken at issue, so later writes never leak in.
        if (w_rd_issue) begin
            fwd_mask_d = w_fwd_mask;
            fwd_data_d = w_fwd_data;
        end
        // Issue requires the response slot free (or freeing), so capture
        // never overwrites a held response.
        if (rd_inflight_q) begin
            resp_valid_d = 1'b1;
            resp_data_d  = lane_merge(fwd_mask_q, fwd_data_q, arr_rdata_i);
        end else if (resp_valid_q && host.resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_inflight_q <= 1'b0;
            fwd_mask_q    <= '0;
            fwd_data_q    <= '0;
            resp_valid_q  <= 1'b0;
            resp_data_q   <= '0;
        end else begin
            rd_inflight_q <= rd_inflight_d;
            fwd_mask_q    <= fwd_mask_d;
            fwd_data_q    <= fwd_data_d;
            resp_valid_q  <= resp_valid_d;
            resp_data_q   <= resp_data_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_wbuf_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_wbuf_ctrl
// Purpose  : Self-checking bench for sram_wbuf_ctrl: per-cycle vector table
//            plus a hand-written asynchronous-reset sequence, with a
//            behavioural masked SRAM on the array port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_wbuf_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         arr_en, arr_wmode;
    logic [4:0]   arr_addr;
    logic [7:0]   arr_wmask;
    logic [255:0] arr_wdata;
    logic [255:0] arr_rdata;
    logic [255:0] mem [32];
    int           wr_cnt;
    int           checks = 0;
    int           errors = 0;

    sram_wbuf_ctrl_if bus ();

    sram_wbuf_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .host        (bus),
        .arr_en_o    (arr_en),
        .arr_wmode_o (arr_wmode),
        .arr_addr_o  (arr_addr),
        .arr_wmask_o (arr_wmask),
        .arr_wdata_o (arr_wdata),
        .arr_rdata_i (arr_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] wpat(input logic [7:0] s);
        logic [255:0] r;
        for (int l = 0; l < 8; l++) r[l*32 +: 32] = {s, s, 8'hEE, 8'(l)};
        return r;
    endfunction

    function automatic logic [255:0] init_row(input logic [4:0] a);
        logic [255:0] r;
        for (int l = 0; l < 8; l++) r[l*32 +: 32] = {16'hC0DE, 3'b000, a, 8'(l)};
        return r;
    endfunction

    function automatic logic [255:0] mix(input logic [7:0] m, input logic [255:0] a, input logic [255:0] b);
        logic [255:0] r;
        for (int l = 0; l < 8; l++) r[l*32 +: 32] = m[l] ? a[l*32 +: 32] : b[l*32 +: 32];
        return r;
    endfunction

    function automatic logic [255:0] lmask(input logic [7:0] m);
        logic [255:0] r;
        for (int l = 0; l < 8; l++) r[l*32 +: 32] = m[l] ? 32'hFFFF_FFFF : 32'h0;
        return r;
    endfunction

    // Behavioural array: synchronous masked write, read data valid next cycle.
    initial begin
        for (int a = 0; a < 32; a++) mem[a] = init_row(5'(a));
        wr_cnt    = 0;
        arr_rdata = '0;
        forever begin
            @(posedge clk);
            if (arr_en) begin
                if (arr_wmode) begin
                    for (int l = 0; l < 8; l++)
                        if (arr_wmask[l]) mem[arr_addr][l*32 +: 32] <= arr_wdata[l*32 +: 32];
                    wr_cnt <= wr_cnt + 1;
                end else begin
                    arr_rdata <= mem[arr_addr];
                end
            end
        end
    end

    typedef struct {
        logic         v, w;
        logic [4:0]   a;
        logic [7:0]   m;
        logic [255:0] d;
        logic         rr;
        logic         rdy, en, wm;
        logic [4:0]   ea;
        logic [7:0]   em;
        logic [255:0] ewd;
        logic         rv;
        logic [255:0] erd;
    } vec_t;

    function automatic vec_t V(input logic v, input logic w, input logic [4:0] a, input logic [7:0] m,
                               input logic [255:0] d, input logic rr, input logic rdy, input logic en,
                               input logic wm, input logic [4:0] ea, input logic [7:0] em,
                               input logic [255:0] ewd, input logic rv, input logic [255:0] erd);
        vec_t t;
        t.v = v; t.w = w; t.a = a; t.m = m; t.d = d; t.rr = rr;
        t.rdy = rdy; t.en = en; t.wm = wm; t.ea = ea; t.em = em; t.ewd = ewd; t.rv = rv; t.erd = erd;
        return t;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic w, input logic [4:0] a, input logic [7:0] m,
                         input logic [255:0] d, input logic rr);
        bus.req_valid  = v;
        bus.req_write  = w;
        bus.req_addr   = a;
        bus.req_wmask  = m;
        bus.req_wdata  = d;
        bus.resp_ready = rr;
    endtask

    vec_t vecs[$];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [255:0] w11, w22, w33, w44, w55, w66, w77, w88, c7;
        w11 = wpat(8'h11); w22 = wpat(8'h22); w33 = wpat(8'h33); w44 = wpat(8'h44);
        w55 = wpat(8'h55); w66 = wpat(8'h66); w77 = wpat(8'h77); w88 = wpat(8'h88);
        c7  = mix(8'h0F, w33, w44);

        //                v  w  a  m      d    rr  rdy en wm ea m      ewd  rv erd
        // write 3 full, read 3 forwarded, then single drain
        vecs.push_back(V(1, 1, 3, 8'hFF, w11, 1,  1, 0, 0, 0, 8'h00, '0,  0, '0));
        vecs.push_back(V(1, 0, 3, 8'h00, '0,  1,  1, 1, 0, 3, 8'h00, '0,  0, '0));
        vecs.push_back(V(0, 0, 0, 8'h00, '0,  1,  0, 1, 1, 3, 8'hFF, w11, 0, '0));
        vecs.push_back(V(0, 0, 0, 8'h00, '0,  0,  0, 0, 0, 0, 8'h00, '0,  1, w11));
        vecs.push_back(V(0, 0, 0, 8'h00, '0,  1,  0, 0, 0, 0, 8'h00, '0,  1, w11));
        vecs.push_back(V(0, 0, 0, 8'h00, '0,  1,  0, 0, 0, 0, 8'h00, '0,  0, '0));
        // partial write 5 lane0, immediate read merges with old array lanes
        vecs.push_back(V(1, 1, 5, 8'h01, w22, 1,  1, 0, 0, 0, 8'h00, '0,  0, '0));
        vecs.push_back(V(1, 0, 5, 8'h00, '0,  1,  1, 1, 0, 5, 8'h00, '0,  0, '0));
        vecs.push_back(V(0, 0, 0, 8'h00, '0,  1,  0, 1, 1, 5, 8'h01, w22, 0, '0));
        vecs.push_back(V(0, 0, 0, 8'h00, '0,  1,  0, 0, 0, 0, 8'h00, '0,  1, mix(8'h01, w22, init_row(5))));
        // back-to-back writes to 7 coalesce into one array write
        vecs.push_back(V(1, 1, 7, 8'h0F, w33, 1,  1, 0, 0, 0, 8'h00, '0,  0, '0));
        vecs.push_back(V(1, 1, 7, 8'hF0, w44, 1,  1, 0, 0, 0, 8'h00, '0,  0, '0));
        vecs.push_back(V(0, 0, 0, 8'h00, '0,  1,  0, 1, 1, 7, 8'hFF, c7,  0, '0));
        vecs.push_back(V(1, 0, 7, 8'h00, '0,  1,  1, 1, 0, 7, 8'h00, '0,  0, '0));
        vecs.push_back(V(0, 0, 0, 8'h00, '0,  1,  0, 0, 0, 0, 8'h00, '0,  0, '0));
        vecs.push_back(V(0, 0, 0, 8'h00, '0,  1,  0, 0, 0, 0, 8'h00, '0,  1, c7));
        // fill buffer, write while full drains head, read stalls while full
        vecs.push_back(V(1, 1, 1, 8'hFF, w55, 1,  1, 0, 0, 0, 8'h00, '0,  0, '0));
        vecs.push_back(V(1, 1, 2, 8'hFF, w66, 1,  1, 0, 0, 0, 8'h00, '0,  0, '0));
        vecs.push_back(V(1, 1, 4, 8'hFF, w77, 1,  1, 1, 1, 1, 8'hFF, w55, 0, '0));
        vecs.push_back(V(1, 0, 2, 8'h00, '0,  1,  0, 1, 1, 2, 8'hFF, w66, 0, '0));
        vecs.push_back(V(1, 0, 2, 8'h00, '0,  1,  1, 1, 0, 2, 8'h00, '0,  0, '0));
        vecs.push_back(V(0, 0, 0, 8'h00, '0,  1,  0, 1, 1, 4, 8'hFF, w77, 0, '0));
        vecs.push_back(V(0, 0, 0, 8'h00, '0,  1,  0, 0, 0, 0, 8'h00, '0,  1, w66));
        // response held with resp_ready low; next read blocked until fire
        vecs.push_back(V(1, 0, 3, 8'h00, '0,  0,  1, 1, 0, 3, 8'h00, '0,  0, '0));
        vecs.push_back(V(1, 0, 4, 8'h00, '0,  0,  0, 0, 0, 0, 8'h00, '0,  0, '0));
        for (int k = 0; k < 4; k++)
            vecs.push_back(V(1, 0, 4, 8'h00, '0, 0, 0, 0, 0, 0, 8'h00, '0, 1, w11));
        vecs.push_back(V(1, 0, 4, 8'h00, '0,  1,  1, 1, 0, 4, 8'h00, '0,  1, w11));
        vecs.push_back(V(0, 0, 0, 8'h00, '0,  1,  0, 0, 0, 0, 8'h00, '0,  0, '0));
        vecs.push_back(V(0, 0, 0, 8'h00, '0,  1,  0, 0, 0, 0, 8'h00, '0,  1, w77));
        vecs.push_back(V(0, 0, 0, 8'h00, '0,  1,  0, 0, 0, 0, 8'h00, '0,  0, '0));

        // reset state
        rst_n = 1'b0;
        drive(0, 0, 0, 8'h00, '0, 1);
        repeat (2) @(negedge clk);
        #1;
        chk("rst resp_valid", -1, 256'(bus.resp_valid), 256'(0));
        chk("rst resp_data",  -1, bus.resp_data, '0);
        chk("rst arr_en",     -1, 256'(arr_en), 256'(0));
        chk("rst arr_wmode",  -1, 256'(arr_wmode), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].v, vecs[i].w, vecs[i].a, vecs[i].m, vecs[i].d, vecs[i].rr);
            #1;
            if (vecs[i].v) chk("req_ready", i, 256'(bus.req_ready), 256'(vecs[i].rdy));
            chk("arr_en", i, 256'(arr_en), 256'(vecs[i].en));
            if (vecs[i].en) begin
                chk("arr_wmode", i, 256'(arr_wmode), 256'(vecs[i].wm));
                chk("arr_addr",  i, 256'(arr_addr), 256'(vecs[i].ea));
            end
            if (vecs[i].wm) begin
                chk("arr_wmask", i, 256'(arr_wmask), 256'(vecs[i].em));
                chk("arr_wdata", i, arr_wdata & lmask(vecs[i].em), vecs[i].ewd & lmask(vecs[i].em));
            end
            chk("resp_valid", i, 256'(bus.resp_valid), 256'(vecs[i].rv));
            if (vecs[i].rv) chk("resp_data", i, bus.resp_data, vecs[i].erd);
        end

        // async reset with a buffered write and a read in flight
        @(negedge clk);
        drive(1, 1, 6, 8'hFF, w88, 1);
        #1;
        chk("r0 req_ready", 100, 256'(bus.req_ready), 256'(1));
        @(negedge clk);
        drive(1, 0, 6, 8'h00, '0, 1);
        #1;
        chk("r1 arr_en",   101, 256'(arr_en), 256'(1));
        chk("r1 arr_wmode",101, 256'(arr_wmode), 256'(0));
        @(negedge clk);
        drive(0, 0, 0, 8'h00, '0, 1);
        rst_n = 1'b0;
        #1;
        chk("r2 resp_valid", 102, 256'(bus.resp_valid), 256'(0));
        chk("r2 resp_data",  102, bus.resp_data, '0);
        chk("r2 arr_en",     102, 256'(arr_en), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("r3 arr_en",     103, 256'(arr_en), 256'(0));
        chk("r3 resp_valid", 103, 256'(bus.resp_valid), 256'(0));
        @(negedge clk);
        #1;
        chk("r4 arr_en",     104, 256'(arr_en), 256'(0));
        chk("r4 resp_valid", 104, 256'(bus.resp_valid), 256'(0));
        @(negedge clk);
        drive(1, 0, 6, 8'h00, '0, 1);
        #1;
        chk("r5 req_ready", 105, 256'(bus.req_ready), 256'(1));
        chk("r5 arr_en",    105, 256'(arr_en), 256'(1));
        chk("r5 arr_addr",  105, 256'(arr_addr), 256'(6));
        @(negedge clk);
        drive(0, 0, 0, 8'h00, '0, 1);
        #1;
        chk("r6 resp_valid", 106, 256'(bus.resp_valid), 256'(0));
        @(negedge clk);
        #1;
        chk("r7 resp_valid", 107, 256'(bus.resp_valid), 256'(1));
        chk("r7 resp_data",  107, bus.resp_data, init_row(5'd6));

        // array contents and total write count
        chk("mem5",   200, mem[5], mix(8'h01, w22, init_row(5'd5)));
        chk("mem7",   201, mem[7], c7);
        chk("mem6",   202, mem[6], init_row(5'd6));
        chk("wr_cnt", 203, 256'(wr_cnt), 256'(6));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
